// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, bus codes, FSM states and control-word layout for the sequencer
package proc_pkg;

    localparam logic [5:0] OP_NOP    = 6'h00;
    localparam logic [5:0] OP_LDAC   = 6'h01;
    localparam logic [5:0] OP_STAC   = 6'h02;
    localparam logic [5:0] OP_MVACR1 = 6'h03;
    localparam logic [5:0] OP_MVR1AC = 6'h04;
    localparam logic [5:0] OP_ADD    = 6'h05;
    localparam logic [5:0] OP_INCAC  = 6'h06;
    localparam logic [5:0] OP_JMP    = 6'h07;
    localparam logic [5:0] OP_JMPZ   = 6'h08;
    localparam logic [5:0] OP_INCRA  = 6'h09;
    localparam logic [5:0] OP_INCRB  = 6'h0A;
    localparam logic [5:0] OP_INCRC  = 6'h0B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam logic [3:0] SEL_AR = 4'd0;
    localparam logic [3:0] SEL_DR = 4'd1;
    localparam logic [3:0] SEL_R1 = 4'd2;
    localparam logic [3:0] SEL_R2 = 4'd3;
    localparam logic [3:0] SEL_R3 = 4'd4;
    localparam logic [3:0] SEL_RA = 4'd5;
    localparam logic [3:0] SEL_RB = 4'd6;
    localparam logic [3:0] SEL_RC = 4'd7;
    localparam logic [3:0] SEL_AC = 4'd8;
    localparam logic [3:0] SEL_PC = 4'd9;

    localparam int C_PC = 9;
    localparam int C_RA = 8;
    localparam int C_RB = 7;
    localparam int C_RC = 6;
    localparam int C_R1 = 5;
    localparam int C_R2 = 4;
    localparam int C_R3 = 3;
    localparam int C_DR = 2;
    localparam int C_AR = 1;
    localparam int C_AC = 0;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;

    typedef enum logic [4:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_DEC,
        S_O1, S_O2, S_O3, S_LD_RD, S_LD_AC, S_ST_DR, S_ST_WR,
        S_MVACR1, S_MVR1AC, S_ADD, S_INCAC, S_INCRA, S_INCRB, S_INCRC,
        S_J1, S_J2, S_JP, S_SKIP, S_HALT
    } state_t;

    typedef struct packed {
        logic [9:0] c_bus;
        logic [3:0] sel;
        logic       ldir;
        logic       pc_inc;
        logic       ac_inc;
        logic       ra_inc;
        logic       rb_inc;
        logic       rc_inc;
        logic [2:0] alu_op;
        logic       mem_rd;
        logic       mem_wr;
        logic       dr_read;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/control_word_decode.sv
// control_word_decode: maps the sequencer state (plus mem_ack in read waits) to the control word
module control_word_decode
    import proc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ack,
    output ctrl_t  cw
);

    // Moore decode; only the read-wait acknowledgements depend on mem_ack
    always_comb begin
        cw = '0;
        case (state)
            S_F1, S_O1, S_J1: begin cw.sel = SEL_PC; cw.alu_op = ALU_PASS; cw.c_bus[C_AR] = 1'b1; end
            S_F2, S_O2:       begin cw.mem_rd = 1'b1; cw.dr_read = mem_ack; cw.pc_inc = mem_ack; end
            S_LD_RD, S_J2:    begin cw.mem_rd = 1'b1; cw.dr_read = mem_ack; end
            S_F3:             cw.ldir = 1'b1;
            S_O3:             begin cw.sel = SEL_DR; cw.c_bus[C_AR] = 1'b1; end
            S_LD_AC:          begin cw.sel = SEL_DR; cw.c_bus[C_AC] = 1'b1; end
            S_ST_DR:          begin cw.sel = SEL_AC; cw.c_bus[C_DR] = 1'b1; end
            S_ST_WR:          cw.mem_wr = 1'b1;
            S_MVACR1:         begin cw.sel = SEL_AC; cw.c_bus[C_R1] = 1'b1; end
            S_MVR1AC:         begin cw.sel = SEL_R1; cw.c_bus[C_AC] = 1'b1; end
            S_ADD:            begin cw.sel = SEL_R1; cw.alu_op = ALU_ADD; cw.c_bus[C_AC] = 1'b1; end
            S_INCAC:          cw.ac_inc = 1'b1;
            S_INCRA:          cw.ra_inc = 1'b1;
            S_INCRB:          cw.rb_inc = 1'b1;
            S_INCRC:          cw.rc_inc = 1'b1;
            S_JP:             begin cw.sel = SEL_DR; cw.c_bus[C_PC] = 1'b1; end
            S_SKIP:           cw.pc_inc = 1'b1;
            S_HALT:           cw.halted = 1'b1;
            default:          cw = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute FSM driving register unit, ALU and RAM handshake
module control_sequencer
    import proc_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int SELW = 4
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [OPW-1:0]  opcode,
    input  logic            z_flag,
    input  logic            mem_ack,
    output logic [9:0]      C_bus_ctrl_sig,
    output logic [SELW-1:0] select,
    output logic            LDIR,
    output logic            PC_INC,
    output logic            AC_INC,
    output logic            RA_INC,
    output logic            RB_INC,
    output logic            RC_INC,
    output logic [2:0]      alu_op,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            dr_read,
    output logic            halted,
    output logic            illegal_op
);

    state_t state, next;
    ctrl_t  cw;
    logic   legal;

    assign legal = (opcode <= OPW'(OP_INCRC)) || (opcode == OPW'(OP_HALT));

    // State register; reset also drops any outstanding memory request
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next;
    end

    // Next-state: waits hold until mem_ack, DEC dispatches on the IR opcode
    always_comb begin
        next = state;
        case (state)
            S_IDLE:   next = run ? S_F1 : S_IDLE;
            S_F1:     next = S_F2;
            S_F2:     next = mem_ack ? S_F3 : S_F2;
            S_F3:     next = S_DEC;
            S_DEC: begin
                case (opcode)
                    OPW'(OP_LDAC), OPW'(OP_STAC): next = S_O1;
                    OPW'(OP_MVACR1):              next = S_MVACR1;
                    OPW'(OP_MVR1AC):              next = S_MVR1AC;
                    OPW'(OP_ADD):                 next = S_ADD;
                    OPW'(OP_INCAC):               next = S_INCAC;
                    OPW'(OP_INCRA):               next = S_INCRA;
                    OPW'(OP_INCRB):               next = S_INCRB;
                    OPW'(OP_INCRC):               next = S_INCRC;
                    OPW'(OP_JMP):                 next = S_J1;
                    OPW'(OP_JMPZ):                next = z_flag ? S_J1 : S_SKIP;
                    OPW'(OP_HALT):                next = S_HALT;
                    default:                      next = S_F1;
                endcase
            end
            S_O1:     next = S_O2;
            S_O2:     next = mem_ack ? S_O3 : S_O2;
            S_O3:     next = (opcode == OPW'(OP_STAC)) ? S_ST_DR : S_LD_RD;
            S_LD_RD:  next = mem_ack ? S_LD_AC : S_LD_RD;
            S_ST_DR:  next = S_ST_WR;
            S_ST_WR:  next = mem_ack ? S_F1 : S_ST_WR;
            S_J1:     next = S_J2;
            S_J2:     next = mem_ack ? S_JP : S_J2;
            S_HALT:   next = S_HALT;
            default:  next = S_F1;
        endcase
    end

    control_word_decode u_decode (
        .state   (state),
        .mem_ack (mem_ack),
        .cw      (cw)
    );

    // Output mapping from the decoded control word; illegal_op lasts exactly the DEC cycle
    always_comb begin
        C_bus_ctrl_sig = cw.c_bus;
        select         = SELW'(cw.sel);
        LDIR           = cw.ldir;
        PC_INC         = cw.pc_inc;
        AC_INC         = cw.ac_inc;
        RA_INC         = cw.ra_inc;
        RB_INC         = cw.rb_inc;
        RC_INC         = cw.rc_inc;
        alu_op         = cw.alu_op;
        mem_rd         = cw.mem_rd;
        mem_wr         = cw.mem_wr;
        dr_read        = cw.dr_read;
        halted         = cw.halted;
        illegal_op     = (state == S_DEC) && !legal;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: instruction-level reference model with randomized opcodes, flags and ack delays
module tb_control_sequencer;

    typedef struct packed {
        logic [9:0] c;
        logic [3:0] sel;
        logic       ldir;
        logic       pci;
        logic       aci;
        logic       rai;
        logic       rbi;
        logic       rci;
        logic [2:0] alu;
        logic       rd;
        logic       wr;
        logic       drr;
        logic       halt;
        logic       ill;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       z_flag = 1'b0;
    logic       mem_ack = 1'b0;
    logic [9:0] C_bus_ctrl_sig;
    logic [3:0] select;
    logic       LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC;
    logic [2:0] alu_op;
    logic       mem_rd, mem_wr, dr_read, halted, illegal_op;
    obs_t       got;
    int         n_checks = 0;
    int         n_fails = 0;
    int         fixed_wait = -1;

    control_sequencer #(.OPW(6), .SELW(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .opcode         (opcode),
        .z_flag         (z_flag),
        .mem_ack        (mem_ack),
        .C_bus_ctrl_sig (C_bus_ctrl_sig),
        .select         (select),
        .LDIR           (LDIR),
        .PC_INC         (PC_INC),
        .AC_INC         (AC_INC),
        .RA_INC         (RA_INC),
        .RB_INC         (RB_INC),
        .RC_INC         (RC_INC),
        .alu_op         (alu_op),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .dr_read        (dr_read),
        .halted         (halted),
        .illegal_op     (illegal_op)
    );

    always #5 clk = ~clk;

    assign got = {C_bus_ctrl_sig, select, LDIR, PC_INC, AC_INC, RA_INC, RB_INC, RC_INC,
                  alu_op, mem_rd, mem_wr, dr_read, halted, illegal_op};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance past the next rising edge
    task automatic step(input string tag, input obs_t e);
        @(negedge clk);
        check(tag, 32'(got), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // Non-wait cycle; a stray ack here must have no effect
    task automatic fixed(input string tag, input obs_t e);
        mem_ack = 1'($urandom_range(0, 1));
        step(tag, e);
    endtask

    function automatic obs_t xfer(input logic [3:0] sel, input int dst);
        obs_t e;
        e = '0;
        e.sel = sel;
        e.c[dst] = 1'b1;
        return e;
    endfunction

    // A RAM transaction: request held for n idle cycles, then the ack cycle
    task automatic mem_wait(input string tag, input logic wr, input logic inc_pc);
        int   n;
        obs_t e;
        n = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        e = '0;
        e.rd = !wr;
        e.wr = wr;
        mem_ack = 1'b0;
        repeat (n) step({tag, "_wait"}, e);
        mem_ack = 1'b1;
        e.pci = inc_pc;
        e.drr = !wr;
        step({tag, "_ack"}, e);
        mem_ack = 1'b0;
    endtask

    task automatic jump();
        fixed("J_arpc", xfer(4'd9, 1));
        mem_wait("J_rd", 1'b0, 1'b0);
        fixed("J_pc", xfer(4'd1, 9));
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, starting in F1
    task automatic run_instr(input logic [5:0] op, input logic z);
        obs_t e;
        opcode = op;
        z_flag = z;
        fixed("F1", xfer(4'd9, 1));
        mem_wait("F2", 1'b0, 1'b1);
        e = '0; e.ldir = 1'b1;
        fixed("F3", e);
        e = '0; e.ill = !(op <= 6'h0B || op == 6'h3F);
        fixed("DEC", e);
        z_flag = 1'($urandom_range(0, 1));
        case (op)
            6'h01, 6'h02: begin
                fixed("O1", xfer(4'd9, 1));
                mem_wait("O2", 1'b0, 1'b1);
                fixed("O3", xfer(4'd1, 1));
                if (op == 6'h01) begin
                    mem_wait("LD_rd", 1'b0, 1'b0);
                    fixed("LD_ac", xfer(4'd1, 0));
                end else begin
                    fixed("ST_dr", xfer(4'd8, 2));
                    mem_wait("ST_wr", 1'b1, 1'b0);
                end
            end
            6'h03: fixed("MVACR1", xfer(4'd8, 5));
            6'h04: fixed("MVR1AC", xfer(4'd2, 0));
            6'h05: begin e = xfer(4'd2, 0); e.alu = 3'd1; fixed("ADD", e); end
            6'h06: begin e = '0; e.aci = 1'b1; fixed("INCAC", e); end
            6'h09: begin e = '0; e.rai = 1'b1; fixed("INCRA", e); end
            6'h0A: begin e = '0; e.rbi = 1'b1; fixed("INCRB", e); end
            6'h0B: begin e = '0; e.rci = 1'b1; fixed("INCRC", e); end
            6'h07: jump();
            6'h08: begin
                if (z) jump();
                else begin e = '0; e.pci = 1'b1; fixed("SKIP", e); end
            end
            6'h3F: begin
                e = '0; e.halt = 1'b1;
                repeat (6) begin
                    run = 1'($urandom_range(0, 1));
                    fixed("HALT", e);
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        obs_t e;
        logic [5:0] op;
        int r;
        rst_n = 1'b0;
        run = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        step("rst0", '0);
        step("rst1", '0);
        rst_n = 1'b1;
        step("idle_run", '0);
        fixed_wait = 0;
        run_instr(6'h00, 1'b0);
        run_instr(6'h00, 1'b0);
        fixed_wait = 3;
        run_instr(6'h01, 1'b0);
        fixed_wait = -1;
        run_instr(6'h02, 1'b1);
        run_instr(6'h08, 1'b0);
        run_instr(6'h08, 1'b1);
        run_instr(6'h15, 1'b0);
        for (int i = 0; i <= 11; i++) run_instr(6'(i), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 13));
            op = (r <= 11) ? 6'(r) : (r == 12) ? 6'($urandom_range(12, 62)) : 6'h08;
            run_instr(op, 1'($urandom_range(0, 1)));
        end
        run_instr(6'h3F, 1'b0);
        rst_n = 1'b0;
        e = '0; e.halt = 1'b1;
        step("halt_rst", e);
        step("post_halt", '0);
        rst_n = 1'b1;
        run = 1'b0;
        step("idle_norun0", '0);
        step("idle_norun1", '0);
        run = 1'b1;
        step("idle_go", '0);
        fixed("F1", xfer(4'd9, 1));
        mem_ack = 1'b0;
        e = '0; e.rd = 1'b1;
        step("F2_hold", e);
        rst_n = 1'b0;
        step("F2_rst", e);
        mem_ack = 1'b1;
        step("abort", '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
